// File: rtl/piso_shiftreg.sv
// Parallel-in / serial-out transmitter. It shifts a WIDTH-bit word out LSB
// first. A word can be loaded on the last bit of the current frame, so
// back-to-back frames have no idle cycle between them.
module piso_shiftreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pi,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             so,
    output logic             so_valid,
    output logic             done,
    output logic             busy
);

    // Handshake: a word transfers on a rising edge where in_valid and
    // in_ready are both 1. in_ready depends only on state and counter. It
    // never depends on in_valid. While in_ready is 0 the sender holds
    // in_valid and pi steady, and pi is not sampled.

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             xfer;

    // The last bit of the frame is on so when the counter reaches WIDTH-1.
    assign last_bit = (state == SHIFT) && (cnt == LAST);
    assign xfer     = in_valid && in_ready;

    // The block can accept a word when idle, or on the final bit of a frame.
    always_comb begin
        in_ready = (state == IDLE) || last_bit;
        so       = (state == SHIFT) && sr[0];
        so_valid = (state == SHIFT);
        busy     = (state == SHIFT);
        done     = last_bit;
    end

    // State, shift register and bit counter. Reset wins over a transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
        end else if (xfer) begin
            state <= SHIFT;
            sr    <= pi;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            sr <= {1'b0, sr[WIDTH-1:1]};
            if (last_bit) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_piso_shiftreg.sv
// Directed bench for piso_shiftreg (WIDTH=8). A table of per-cycle
// {inputs, expected outputs} rows is applied in a loop. A hand-written
// loopback through a SIPO model follows the table.
module tb_piso_shiftreg;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] pi;
    logic         in_valid;
    logic         in_ready;
    logic         so;
    logic         so_valid;
    logic         done;
    logic         busy;

    int checks;
    int errors;

    typedef struct {
        logic         rst;
        logic         iv;
        logic [W-1:0] pi;
        logic         so;
        logic         sv;
        logic         dn;
        logic         bs;
        logic         rdy;
    } vec_t;

    vec_t vq[$];

    // Receiver model: an 8-bit SIPO that takes so in LSB first.
    logic [W-1:0] po;

    piso_shiftreg #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .pi       (pi),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .so       (so),
        .so_valid (so_valid),
        .done     (done),
        .busy     (busy)
    );

    // Clock: 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Receiver model shifts in one bit on each valid cycle.
    always @(posedge clk) begin
        if (so_valid) po <= {so, po[W-1:1]};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic iv, input logic [W-1:0] p,
                       input logic eso, input logic esv, input logic edn,
                       input logic ebs, input logic erdy);
        vec_t v;
        v.rst = r;  v.iv = iv;  v.pi = p;
        v.so = eso; v.sv = esv; v.dn = edn; v.bs = ebs; v.rdy = erdy;
        vq.push_back(v);
    endtask

    // Eight frame cycles of a word. Inputs for each cycle come from iv_at and
    // pi_at. Expected bits are taken LSB first.
    task automatic add_frame(input logic [W-1:0] word, input logic [W-1:0] iv_at,
                             input logic [W-1:0] pi_lo, input logic [W-1:0] pi_hi,
                             input int pi_switch);
        for (int k = 0; k < W; k++) begin
            add(1'b0, iv_at[k], (k < pi_switch) ? pi_lo : pi_hi,
                word[k], 1'b1, (k == W - 1), 1'b1, (k == W - 1));
        end
    endtask

    task automatic add_idle(input logic r, input logic iv, input logic [W-1:0] p);
        add(r, iv, p, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int budget;
        logic [W-1:0] exp_po;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        pi = '0;
        po = '0;

        // Reset state.
        add_idle(1'b0, 1'b0, 8'h00);
        // Single frame of A5.
        add_idle(1'b0, 1'b1, 8'hA5);
        add_frame(8'hA5, 8'h00, 8'h00, 8'h00, 0);
        add_idle(1'b0, 1'b0, 8'h00);
        // Back to back: FF, then 00 held from cycle 2 (k=1 onward).
        add_idle(1'b0, 1'b1, 8'hFF);
        add_frame(8'hFF, 8'hFE, 8'h00, 8'h00, 0);
        add_frame(8'h00, 8'h00, 8'h00, 8'h00, 0);
        add_idle(1'b0, 1'b0, 8'h00);
        // Stall: frame 81, with pi 11 during k=1..3 and 22 during k=4..7.
        add_idle(1'b0, 1'b1, 8'h81);
        add_frame(8'h81, 8'hFE, 8'h11, 8'h22, 4);
        add_frame(8'h22, 8'h00, 8'h00, 8'h00, 0);
        add_idle(1'b0, 1'b0, 8'h00);
        // Reset in cycle 4 of an F0 frame.
        add_idle(1'b0, 1'b1, 8'hF0);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        add_idle(1'b0, 1'b1, 8'h01);
        add_frame(8'h01, 8'h00, 8'h00, 8'h00, 0);
        add_idle(1'b0, 1'b0, 8'h00);
        // Reset together with a transfer of AA: no frame is emitted.
        add_idle(1'b1, 1'b1, 8'hAA);
        add_idle(1'b0, 1'b0, 8'h00);
        add_idle(1'b0, 1'b0, 8'h00);

        tick();
        tick();
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            rst      = vq[i].rst;
            in_valid = vq[i].iv;
            pi       = vq[i].pi;
            checks++;
            if ({so, so_valid, done, busy, in_ready} !=
                {vq[i].so, vq[i].sv, vq[i].dn, vq[i].bs, vq[i].rdy}) begin
                errors++;
                $display("FAIL row %0d: so/sv/done/busy/rdy got %b%b%b%b%b want %b%b%b%b%b",
                         i, so, so_valid, done, busy, in_ready,
                         vq[i].so, vq[i].sv, vq[i].dn, vq[i].bs, vq[i].rdy);
            end
            tick();
        end
        rst = 1'b0;
        in_valid = 1'b0;

        // Loopback into the receiver model with 3C.
        exp_po = 8'h3C;
        in_valid = 1'b1;
        pi = exp_po;
        tick();
        in_valid = 1'b0;
        pi = '0;
        budget = 0;
        while (!done && budget < 20) begin
            tick();
            budget++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL loopback_done: done never asserted within 20 cycles");
        end
        tick();
        checks++;
        if (po !== exp_po) begin
            errors++;
            $display("FAIL loopback_po: got %h want %h", po, exp_po);
        end
        checks++;
        if ({so_valid, busy, in_ready} !== 3'b001) begin
            errors++;
            $display("FAIL loopback_idle: sv/busy/rdy got %b%b%b want 001",
                     so_valid, busy, in_ready);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
